// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states
// and a small index-to-one-hot helper.
package alu_arb_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// 8-bit combinational ALU; cout is the ADD carry or the SUB no-borrow flag
// (A >= B), and zero for the logic operations.
module alu
    import alu_arb_pkg::*;
(
    input  logic [1:0] op,
    input  logic [7:0] i0,
    input  logic [7:0] i1,
    output logic [7:0] o,
    output logic       cout
);

    logic [8:0] sum_s;

    // Nine-bit result so the top bit carries out of ADD and out of A + ~B + 1.
    always_comb begin
        sum_s = 9'd0;
        case (op)
            OP_ADD:  sum_s = {1'b0, i0} + {1'b0, i1};
            OP_SUB:  sum_s = {1'b0, i0} + {1'b0, ~i1} + 9'd1;
            OP_AND:  sum_s = {1'b0, i0 & i1};
            OP_XOR:  sum_s = {1'b0, i0 ^ i1};
            default: sum_s = 9'd0;
        endcase
    end

    assign o    = sum_s[7:0];
    assign cout = sum_s[8];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; each operation
// runs IDLE (accept) -> EXEC (compute) -> RESP (hold until consumed).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter logic PRIO_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_cout,
    output logic        rsp_zero,
    output logic        busy
);

    state_e      state_r, state_nx_s;
    logic        grant_r, grant_sel_s, ptr_r;
    logic        accept_s, done_s;
    logic [1:0]  op_r;
    logic [7:0]  a_r, b_r;
    logic [7:0]  alu_o_s;
    logic        alu_cout_s;
    logic [7:0]  rsp_data_r;
    logic        rsp_cout_r, rsp_zero_r, busy_r;
    logic [1:0]  rsp_valid_r;

    alu u_alu (
        .op   (op_r),
        .i0   (a_r),
        .i1   (b_r),
        .o    (alu_o_s),
        .cout (alu_cout_s)
    );

    // Next-state, grant selection and handshake detection.
    always_comb begin
        state_nx_s  = state_r;
        grant_sel_s = 1'b0;
        accept_s    = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req_valid) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_EXEC;
                    if (req_valid == 2'b11) begin
                        grant_sel_s = ptr_r;
                    end else begin
                        grant_sel_s = req_valid[1];
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nx_s = ST_RESP;
            ST_RESP: begin
                // Only the granted requester's rsp_ready can complete the handshake.
                if (rsp_ready[grant_r]) begin
                    done_s     = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    assign req_ready = (accept_s && rst_n) ? onehot2(grant_sel_s) : 2'b00;

    // State, captured operands, registered response and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            grant_r     <= 1'b0;
            ptr_r       <= PRIO_RESET;
            op_r        <= 2'b00;
            a_r         <= 8'h00;
            b_r         <= 8'h00;
            rsp_data_r  <= 8'h00;
            rsp_cout_r  <= 1'b0;
            rsp_zero_r  <= 1'b0;
            rsp_valid_r <= 2'b00;
            busy_r      <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            if (accept_s) begin
                grant_r <= grant_sel_s;
                op_r    <= req_op[{grant_sel_s, 1'b0} +: 2];
                a_r     <= req_a[{grant_sel_s, 3'b000} +: 8];
                b_r     <= req_b[{grant_sel_s, 3'b000} +: 8];
            end
            if (state_r == ST_EXEC) begin
                rsp_data_r  <= alu_o_s;
                rsp_cout_r  <= ((op_r == OP_ADD) || (op_r == OP_SUB)) ? alu_cout_s : 1'b0;
                rsp_zero_r  <= (alu_o_s == 8'h00);
                rsp_valid_r <= onehot2(grant_r);
            end
            if (done_s) begin
                rsp_valid_r <= 2'b00;
                ptr_r       <= ~grant_r;
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_cout  = rsp_cout_r;
    assign rsp_zero  = rsp_zero_r;
    assign busy      = busy_r;

endmodule
